// File: rtl/alu_exec_unit.sv
// Handshaked RV32I execute unit with decode folded in; defining ALU_EXEC_MDU_EN
// adds the M extension as an iterative (one bit per cycle) mul/div sequencer.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

`ifdef ALU_EXEC_MDU_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_DONE = 1'b1} state_t;
`endif

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND, A_PASSB
  } alu_op_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  alu_op_t           dec_alu;
  logic              dec_ill;
  logic [XLEN-1:0]   alu_res;
  logic [SHW-1:0]    shamt;
  logic              accept;

  function automatic alu_op_t f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_alu = alt ? A_SUB : A_ADD;
      3'b001:  f3_alu = A_SLL;
      3'b010:  f3_alu = A_SLT;
      3'b011:  f3_alu = A_SLTU;
      3'b100:  f3_alu = A_XOR;
      3'b101:  f3_alu = alt ? A_SRA : A_SRL;
      3'b110:  f3_alu = A_OR;
      default: f3_alu = A_AND;
    endcase
  endfunction

`ifdef ALU_EXEC_MDU_EN
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN-1);
  localparam logic [SHW-1:0]  CNT_ONE  = SHW'(1);

  logic                dec_md;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [2:0]          f3_q, f3_d;

  logic                is_div, a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                md_special;
  logic [XLEN-1:0]     md_spec_res;
  logic [XLEN:0]       mul_sum, div_t;
  logic                div_ge;
  logic [2*XLEN-1:0]   acc_step, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, md_res;
`endif

  always_comb begin
    dec_alu = A_ADD;
    dec_ill = 1'b0;
`ifdef ALU_EXEC_MDU_EN
    dec_md  = 1'b0;
`endif
    case (op)
      OP_R: begin
        if (funct7 == 7'b0000000)
          dec_alu = f3_alu(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec_alu = f3_alu(funct3, 1'b1);
`ifdef ALU_EXEC_MDU_EN
        else if (funct7 == 7'b0000001)
          dec_md = 1'b1;
`endif
        else
          dec_ill = 1'b1;
      end
      OP_I:               dec_alu = f3_alu(funct3, funct3 == 3'b101 && funct7[5]);
      OP_LOAD, OP_STORE:  dec_alu = A_ADD;
      OP_BRANCH: begin
        case (funct3[2:1])
          2'b00:   dec_alu = A_SUB;
          2'b10:   dec_alu = A_SLT;
          2'b11:   dec_alu = A_SLTU;
          default: dec_ill = 1'b1;
        endcase
      end
      OP_LUI:  dec_alu = A_PASSB;
      default: dec_ill = 1'b1;
    endcase
  end

  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (dec_alu)
      A_ADD:   alu_res = a + b;
      A_SUB:   alu_res = a - b;
      A_SLL:   alu_res = a << shamt;
      A_SLT:   alu_res[0] = $signed(a) < $signed(b);
      A_SLTU:  alu_res[0] = a < b;
      A_XOR:   alu_res = a ^ b;
      A_SRL:   alu_res = a >> shamt;
      A_SRA:   alu_res = $unsigned($signed(a) >>> shamt);
      A_OR:    alu_res = a | b;
      A_AND:   alu_res = a & b;
      A_PASSB: alu_res = b;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_MDU_EN
  // Operands become magnitudes at accept; sign is re-applied on the last iteration.
  always_comb begin
    is_div      = funct3[2];
    a_sgn       = is_div ? !funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_sgn       = is_div ? !funct3[0] : (funct3 == 3'b001);
    neg_a       = a_sgn & a[XLEN-1];
    neg_b       = b_sgn & b[XLEN-1];
    mag_a       = neg_a ? -a : a;
    mag_b       = neg_b ? -b : b;
    md_special  = 1'b0;
    md_spec_res = '0;
    if (is_div) begin
      if (b == '0) begin
        md_special  = 1'b1;
        md_spec_res = funct3[1] ? a : '1;
      end else if (a_sgn && a == SMIN && b == '1) begin
        md_special  = 1'b1;
        md_spec_res = funct3[1] ? '0 : a;
      end
    end
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q & {XLEN{acc_q[0]}}};
    div_t   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = div_t >= {1'b0, opb_q};
    if (f3_q[2])
      acc_step = {(div_ge ? (div_t[XLEN-1:0] - opb_q) : div_t[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (f3_q[2])
      md_res = f3_q[1] ? rem_fix : quo_fix;
    else
      md_res = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end
`endif

  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_MDU_EN
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    f3_d      = f3_q;
`endif
    case (state_q)
      S_IDLE: begin
      end
`ifdef ALU_EXEC_MDU_EN
      S_BUSY: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          result_d  = md_res;
          zero_d    = (md_res == '0);
          illegal_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An accept in DONE overrides the return to IDLE, giving one result per cycle.
    if (accept) begin
      state_d   = S_DONE;
      illegal_d = dec_ill;
      result_d  = dec_ill ? '0 : alu_res;
`ifdef ALU_EXEC_MDU_EN
      if (dec_md) begin
        if (md_special) begin
          result_d = md_spec_res;
        end else begin
          state_d = S_BUSY;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          opb_d   = mag_b;
          cnt_d   = CNT_LAST;
          neg_d   = (is_div && funct3[1]) ? neg_a : (neg_a ^ neg_b);
          f3_d    = funct3;
        end
      end
`endif
      zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_MDU_EN
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      f3_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_MDU_EN
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      f3_q      <= f3_d;
`endif
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;
`ifdef ALU_EXEC_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_fail  = 0;
  int unsigned busy_ready_seen = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] basic(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (f3)
      3'd0:    basic = alt ? x - y : x + y;
      3'd1:    basic = x << y[4:0];
      3'd2:    basic = (sx < sy) ? 32'd1 : 32'd0;
      3'd3:    basic = (x < y) ? 32'd1 : 32'd0;
      3'd4:    basic = x ^ y;
      3'd5:    basic = alt ? 32'(sx >>> y[4:0]) : x >> y[4:0];
      3'd6:    basic = x | y;
      default: basic = x & y;
    endcase
  endfunction

  function automatic void mext(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] r, output logic iter);
    int sx, sy;
    logic signed [63:0] ex, ey, ezy, pss, psu;
    logic [63:0] puu;
    logic ovf;
    sx  = x;
    sy  = y;
    ex  = sx;
    ey  = sy;
    ezy = $signed({32'd0, y});
    pss = ex * ey;
    psu = ex * ezy;
    puu = {32'd0, x} * {32'd0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    iter = 1'b1;
    case (f3)
      3'd0: r = pss[31:0];
      3'd1: r = pss[63:32];
      3'd2: r = psu[63:32];
      3'd3: r = puu[63:32];
      3'd4: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; iter = 1'b0; end
        else if (ovf) begin r = x; iter = 1'b0; end
        else r = 32'(sx / sy);
      end
      3'd5: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; iter = 1'b0; end
        else r = x / y;
      end
      3'd6: begin
        if (y == 0) begin r = x; iter = 1'b0; end
        else if (ovf) begin r = 32'd0; iter = 1'b0; end
        else r = 32'(sx % sy);
      end
      default: begin
        if (y == 0) begin r = x; iter = 1'b0; end
        else r = x % y;
      end
    endcase
  endfunction

  function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output logic iter);
    r = 32'd0;
    ill = 1'b0;
    iter = 1'b0;
    case (o)
      7'h33: begin
        if (f7 == 7'h00) r = basic(f3, 1'b0, x, y);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) r = basic(f3, 1'b1, x, y);
        else if (f7 == 7'h01 && MDU) mext(f3, x, y, r, iter);
        else ill = 1'b1;
      end
      7'h13: r = basic(f3, f3 == 3'd5 && f7[5], x, y);
      7'h03, 7'h23: r = x + y;
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        else if (f3[2] == 1'b0) r = x - y;
        else r = basic({2'b01, f3[1]}, 1'b0, x, y);
      end
      7'h37: r = y;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic eill, eit;
    int lat, w;
    model(o, f3, f7, x, y, er, eill, eit);
    @(negedge clk);
    op = o; funct3 = f3; funct7 = f7; a = x; b = y;
    in_valid = 1'b1;
    out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    check($sformatf("%s.in_ready", tag), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready_seen++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s.lat", tag), 32'(lat), eit ? 32'(XLEN + 1) : 32'd1);
    check($sformatf("%s.result", tag), result, er);
    check($sformatf("%s.zero", tag), 32'(zero), 32'(er == 32'd0));
    check($sformatf("%s.illegal", tag), 32'(illegal), 32'(eill));
    @(posedge clk); #1;
    check($sformatf("%s.drop", tag), 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       pick_operand = 32'd0;
      1:       pick_operand = 32'd1;
      2:       pick_operand = 32'hFFFF_FFFF;
      3:       pick_operand = 32'h8000_0000;
      default: pick_operand = $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0]  bo[4];
    logic [2:0]  bf3[4];
    logic [6:0]  bf7[4];
    logic [31:0] ba[4], bb[4], bexp[4];
    logic bill, bit_it;
    logic [6:0] ro, rf7;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; funct3 = '0; funct7 = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.zero", 32'(zero), 32'd0);
    check("reset.illegal", 32'(illegal), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);

    run_op("add", 7'h33, 3'd0, 7'h00, 32'd5, 32'd7);
    run_op("beq_sub", 7'h63, 3'd0, 7'h00, 32'h1234, 32'h1234);
    run_op("sra", 7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    run_op("srai", 7'h13, 3'd5, 7'h20, 32'hF000_0010, 32'd33);
    run_op("blt", 7'h63, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1);
    run_op("bgeu", 7'h63, 3'd7, 7'h00, 32'hFFFF_FFFF, 32'd1);
    run_op("br_f3_2", 7'h63, 3'd2, 7'h00, 32'd3, 32'd4);
    run_op("lui", 7'h37, 3'd0, 7'h00, 32'd9, 32'hABCD_E000);
    run_op("bad_op", 7'h7F, 3'd0, 7'h00, 32'd5, 32'd7);
    run_op("r_f7_1", 7'h33, 3'd0, 7'h01, 32'd6, 32'd7);
    run_op("r_f7_bad", 7'h33, 3'd1, 7'h20, 32'd6, 32'd7);

    bo  = '{7'h33, 7'h13, 7'h33, 7'h03};
    bf3 = '{3'd0,  3'd4,  3'd3,  3'd0};
    bf7 = '{7'h00, 7'h00, 7'h00, 7'h00};
    ba  = '{32'd100, 32'hF0F0_F0F0, 32'd1, 32'h1000};
    bb  = '{32'd23,  32'h0FF0_0FF0, 32'd2, 32'hFFFF_FFFC};
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = bo[k]; funct3 = bf3[k]; funct7 = bf7[k]; a = ba[k]; b = bb[k];
      in_valid = 1'b1;
      model(bo[k], bf3[k], bf7[k], ba[k], bb[k], bexp[k], bill, bit_it);
      @(posedge clk); #1;
      check($sformatf("b2b%0d.valid", k), 32'(out_valid), 32'd1);
      check($sformatf("b2b%0d.result", k), result, bexp[k]);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d.valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d.result", k), result, bexp[3]);
      check($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall.release", 32'(out_valid), 32'd0);

    // Reset while a result is held, then normal operation resumes.
    @(negedge clk);
    op = 7'h7F; funct3 = 3'd0; funct7 = 7'h00; a = 32'd1; b = 32'd2;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold.illegal", 32'(illegal), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_hold.valid", 32'(out_valid), 32'd0);
    check("rst_hold.zero", 32'(zero), 32'd0);
    check("rst_hold.illegal", 32'(illegal), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_hold.in_ready", 32'(in_ready), 32'd1);
    run_op("post_rst_add", 7'h33, 3'd0, 7'h00, 32'd40, 32'd2);

`ifdef ALU_EXEC_MDU_EN
    run_op("mulh", 7'h33, 3'd1, 7'h01, 32'hFFFF_FFFE, 32'd3);
    run_op("div0", 7'h33, 3'd4, 7'h01, 32'd7, 32'd0);
    run_op("rem_ovf", 7'h33, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg", 7'h33, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_neg", 7'h33, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2);
    run_op("mulhu", 7'h33, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    @(negedge clk);
    op = 7'h33; funct3 = 3'd5; funct7 = 7'h01; a = 32'd1000; b = 32'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy.in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rst_busy.valid", 32'(out_valid), 32'd0);
    check("rst_busy.result", result, 32'd0);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_busy.in_ready", 32'(in_ready), 32'd1);
    run_op("post_busy_add", 7'h33, 3'd0, 7'h00, 32'd5, 32'd7);
`endif

    for (int i = 0; i < 60; i++) begin
      rf7 = 7'h00;
      case ($urandom_range(0, 8))
        0: begin ro = 7'h33; rf7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
        1: begin ro = 7'h13; rf7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
        2: ro = 7'h03;
        3: ro = 7'h23;
        4: ro = 7'h63;
        5: ro = 7'h37;
        6: ro = 7'($urandom);
        7: begin ro = 7'h33; rf7 = 7'($urandom); end
        default: begin ro = 7'h33; rf7 = 7'h01; end
      endcase
      run_op($sformatf("rnd%0d", i), ro, 3'($urandom), rf7, pick_operand(), pick_operand());
    end

    check("busy_in_ready_seen", busy_ready_seen, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked execute unit for the RISC-V core. It decodes `op`/`funct3`/`funct7` directly, replacing the separate ALUop stage, and covers the full RV32I integer ALU set, including shifts, slt/sltu and branch compares. It optionally adds the M extension, implemented as an iterative multiply/divide sequencer. It sits between the register-read stage and writeback, with valid/ready on both sides.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; power of two, ≥ 8.

Ports:
- `clk`  in  1  clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `op`  in  7  instruction opcode.
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7.
- `a`  in  XLEN  operand A (rs1).
- `b`  in  XLEN  operand B (rs2 or immediate).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  XLEN  registered result.
- `zero`  out  1  registered (`result == 0`).
- `illegal`  out  1  registered; request was not decodable.

## Operation
- Request is accepted on a rising edge with `in_valid && in_ready`.
- Operands and decode fields are captured at that edge.

Decode by `op`:
- 0110011 R-type: by funct3 — add/sub (sub when funct7=0100000), sll, slt, sltu, xor, srl/sra (sra when funct7=0100000), or, and.
- 0010011 I-type: same functions, except funct3=000 is always add. srai is selected by funct7[5] with funct3=101.
- 0000011 load / 0100011 store: add.
- 1100011 branch:
  - beq/bne → sub.
  - blt/bge → slt.
  - bltu/bgeu → sltu.
  - funct3 010/011 → illegal.
- 0110111 LUI: result = b.
- Any other opcode → illegal.
- R-type with funct7 ∉ {0000000, 0100000 with funct3 ∈ {000,101}, 0000001 when MDU enabled} → illegal.

Arithmetic rules:
- Shift amount = b[log2(XLEN)-1:0].
- Add/sub wrap modulo 2^XLEN.
- slt/sltu result is 0 or 1, zero-extended.

Illegal requests: `result`=0, `zero`=1, `illegal`=1, single-cycle completion.

FSM states:
- IDLE → DONE on accept of a single-cycle op.
- IDLE → BUSY on accept of a mul/div op needing iteration.
- BUSY: one bit per cycle. Counter runs from XLEN-1 to 0; at 0, go to DONE.
- DONE: outputs held. On `out_ready`, go to IDLE, or re-accept a new request in the same cycle (see Timing).

Mul/div algorithm:
- Multiply: shift-add on operand magnitudes; signs fixed at the final step.
- Divide: restoring, on magnitudes.
- Divide special cases bypass BUSY (single-cycle):
  - divide by zero: quotient = all ones, remainder = a.
  - signed overflow (a = −2^(XLEN-1), b = −1): quotient = a, remainder = 0.

## Timing
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- Single-cycle ops: `out_valid` rises the cycle after the accept edge, so latency is 1.
- Back-to-back accepts give 1 result per cycle.
- Iterative mul/div: `out_valid` rises XLEN+1 cycles after the accept edge.
- `in_ready`=0 throughout BUSY.
- While `out_valid && !out_ready`, `result`/`zero`/`illegal` must stay stable.
- `out_valid` deasserts after the handshake edge unless a new request was accepted on that edge.
- Reset (`rst`=0, any time, including mid-BUSY):
  - state → IDLE; the iteration is aborted.
  - `out_valid`=0, `result`=0, `zero`=0, `illegal`=0.
  - `in_ready` reads 1 after reset is released.
- No combinational path from `in_*` to `out_*`.

## Configuration
- `ALU_EXEC_MDU_EN` defined:
  - funct7=0000001 R-type decodes mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
  - mul* ops return the low/high XLEN bits of the 2·XLEN product, signedness per RISC-V.
  - BUSY and the iteration datapath are present.
- Undefined:
  - funct7=0000001 → illegal, single-cycle.
  - BUSY state, counter and mul/div datapath are removed.

## Test plan
- add a=5, b=7 (op 0110011, f3 000, f7 0) → `out_valid` 1 cycle later, `result`=12, `zero`=0.
- sub a=b=0x1234 via beq (op 1100011, f3 000) → `result`=0, `zero`=1; then sra a=0x80000000, b=4 → 0xF8000000.
- 4 back-to-back ALU requests with `out_ready` held 1 → 4 results on 4 consecutive cycles. Then drop `out_ready` 3 cycles → `result` held stable, `in_ready`=0.
- MDU enabled, XLEN=32:
  - mulh a=−2, b=3 → `result`=0xFFFFFFFF, `out_valid` 33 cycles after accept.
  - div a=7, b=0 → 0xFFFFFFFF after 1 cycle.
  - rem a=0x80000000, b=−1 → 0.
- Assert `rst`=0 mid-BUSY (cycle 10 of a divu) → `out_valid`=0, `result`=0 immediately. After release, new add request completes normally.
- op 1111111, and R-type f7=0000001 with MDU disabled → `illegal`=1, `result`=0, latency 1.
